// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: opcodes, ALU op codes,
// operand-2 selects and FSM state encodings.
package alu_pkg;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_BZ   = 4'd6;
  localparam logic [3:0] OP_BLTZ = 4'd7;
  localparam logic [3:0] OP_NOP  = 4'd8;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_CMP = 2'b11;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_ZEXT = 2'd1;
  localparam logic [1:0] IMM_SEXT = 2'd2;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CMP_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode decode: ALU op, operand-2 select, branch class
// and illegal-opcode detection.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] alu_op,
  output logic [1:0] imm_sel,
  output logic       issue,
  output logic       is_branch,
  output logic       br_on_neg,
  output logic       illegal
);

  always_comb begin
    alu_op    = ALU_OR;
    imm_sel   = IMM_NONE;
    issue     = 1'b0;
    is_branch = 1'b0;
    br_on_neg = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_OR:   issue = 1'b1;
      OP_ADD:  begin alu_op = ALU_ADD; issue = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; issue = 1'b1; end
      OP_CMP:  begin alu_op = ALU_CMP; issue = 1'b1; end
      OP_ORI:  begin imm_sel = IMM_ZEXT; issue = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; imm_sel = IMM_SEXT; issue = 1'b1; end
      OP_BZ:   is_branch = 1'b1;
      OP_BLTZ: begin is_branch = 1'b1; br_on_neg = 1'b1; end
      OP_NOP:  illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: registers decoded operands into EX, tracks compare flags
// and resolves BZ/BLTZ. Define ALU_ISSUE_FLAG_FWD_EN to forward live flags.
//
// state       | meaning
// ST_RUN      | no compare awaiting its flags
// ST_CMP_PEND | a CMP sits in EX; its flags are not yet in zf/nf
module alu_issue_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_opcode,
  input  logic [n-1:0] in_rs,
  input  logic [n-1:0] in_rt,
  input  logic [15:0]  in_imm,
  input  logic         stall,
  input  logic         flush,
  output logic [n-1:0] alu_in1,
  output logic [n-1:0] alu_in2,
  output logic [1:0]   alu_op,
  output logic         ex_valid,
  input  logic         alu_zero,
  input  logic         alu_neg,
  output logic         br_taken,
  output logic         illegal_op
);
  import alu_pkg::*;

  logic [1:0]   dec_alu_op;
  logic [1:0]   dec_imm_sel;
  logic         dec_issue;
  logic         dec_branch;
  logic         dec_br_neg;
  logic         dec_illegal;
  state_t       state;
  logic         zf, nf, flags_valid;
  logic         branch_block;
  logic         br_zero, br_neg, br_flags_ok;
  logic         accept, flag_load, take_branch;
  logic [n-1:0] op2_next;

  alu_issue_decode u_decode (
    .opcode    (in_opcode),
    .alu_op    (dec_alu_op),
    .imm_sel   (dec_imm_sel),
    .issue     (dec_issue),
    .is_branch (dec_branch),
    .br_on_neg (dec_br_neg),
    .illegal   (dec_illegal)
  );

`ifdef ALU_ISSUE_FLAG_FWD_EN
  // The CMP in EX is valid whenever we are in ST_CMP_PEND, so its live flags are usable.
  assign branch_block = 1'b0;
  always_comb begin
    if (state == ST_CMP_PEND) begin
      br_zero     = alu_zero;
      br_neg      = alu_neg;
      br_flags_ok = 1'b1;
    end else begin
      br_zero     = zf;
      br_neg      = nf;
      br_flags_ok = flags_valid;
    end
  end
`else
  assign branch_block = (state == ST_CMP_PEND) && dec_branch;
  assign br_zero      = zf;
  assign br_neg       = nf;
  assign br_flags_ok  = flags_valid;
`endif

  assign in_ready    = !reset && !stall && !flush && !branch_block;
  assign accept      = in_valid && in_ready;
  assign flag_load   = ex_valid && (alu_op == ALU_CMP) && !flush;
  assign take_branch = accept && dec_branch && br_flags_ok &&
                       (dec_br_neg ? br_neg : br_zero);

  always_comb begin
    case (dec_imm_sel)
      IMM_ZEXT: op2_next = {{(n-16){1'b0}}, in_imm};
      IMM_SEXT: op2_next = {{(n-16){in_imm[15]}}, in_imm};
      default:  op2_next = in_rt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_op      <= ALU_OR;
      ex_valid    <= 1'b0;
      br_taken    <= 1'b0;
      illegal_op  <= 1'b0;
      zf          <= 1'b0;
      nf          <= 1'b0;
      flags_valid <= 1'b0;
      state       <= ST_RUN;
    end else begin
      if (flag_load) begin
        zf          <= alu_zero;
        nf          <= alu_neg;
        flags_valid <= 1'b1;
      end
      if (accept && dec_illegal) illegal_op <= 1'b1;
      if (flush) begin
        ex_valid <= 1'b0;
        br_taken <= 1'b0;
        state    <= ST_RUN;
      end else if (stall) begin
        br_taken <= 1'b0;
      end else begin
        br_taken <= take_branch;
        if (accept && dec_issue) begin
          alu_in1  <= in_rs;
          alu_in2  <= op2_next;
          alu_op   <= dec_alu_op;
          ex_valid <= 1'b1;
        end else begin
          ex_valid <= 1'b0;
        end
        if (accept && dec_issue && (dec_alu_op == ALU_CMP)) state <= ST_CMP_PEND;
        else                                                 state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_alu_issue_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_opcode = 4'd8;
  logic [N-1:0] in_rs = '0;
  logic [N-1:0] in_rt = '0;
  logic [15:0]  in_imm = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [N-1:0] alu_in1, alu_in2;
  logic [1:0]   alu_op;
  logic         ex_valid;
  logic         alu_zero, alu_neg;
  logic         br_taken, illegal_op;

  always #5 clk = ~clk;

  alu_issue_stage #(.n(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .stall      (stall),
    .flush      (flush),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .ex_valid   (ex_valid),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .br_taken   (br_taken),
    .illegal_op (illegal_op)
  );

  // Stand-in ALU feeding flags back to the stage; CMP behaves as a subtract.
  logic [N-1:0] alu_res;
  always_comb begin
    case (alu_op)
      2'b00:   alu_res = alu_in1 | alu_in2;
      2'b01:   alu_res = alu_in1 + alu_in2;
      default: alu_res = alu_in1 - alu_in2;
    endcase
  end
  assign alu_zero = (alu_res == '0);
  assign alu_neg  = alu_res[N-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: contents of the EX slot plus the architectural flags.
  logic         m_ex_valid = 1'b0;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  logic [1:0]   m_op = 2'b00;
  logic         m_br = 1'b0;
  logic         m_ill = 1'b0;
  logic         m_zf = 1'b0, m_nf = 1'b0, m_fv = 1'b0;

  task automatic cyc(input logic rst, input logic v, input logic [3:0] op,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                     input logic st, input logic fl);
    logic         is_br, cmp_in_ex, rdy, acc, taken;
    logic [N-1:0] diff;
    logic         live_z, live_n, use_z, use_n, use_v;
    @(negedge clk);
    check_eq("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
    check_eq("alu_in1", alu_in1, m_a);
    check_eq("alu_in2", alu_in2, m_b);
    check_eq("alu_op", 32'(alu_op), 32'(m_op));
    check_eq("br_taken", 32'(br_taken), 32'(m_br));
    check_eq("illegal_op", 32'(illegal_op), 32'(m_ill));
    reset = rst; in_valid = v; in_opcode = op; in_rs = rs; in_rt = rt;
    in_imm = imm; stall = st; flush = fl;
    #1;
    is_br     = (op == 4'd6) || (op == 4'd7);
    cmp_in_ex = m_ex_valid && (m_op == 2'b11);
`ifdef ALU_ISSUE_FLAG_FWD_EN
    rdy = !rst && !st && !fl;
`else
    rdy = !rst && !st && !fl && !(cmp_in_ex && is_br);
`endif
    check_eq("in_ready", 32'(in_ready), 32'(rdy));
    acc = v && rdy;
    if (rst) begin
      m_ex_valid = 1'b0; m_a = '0; m_b = '0; m_op = 2'b00; m_br = 1'b0;
      m_ill = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_fv = 1'b0;
      return;
    end
    diff   = m_a - m_b;
    live_z = (m_a == m_b);
    live_n = diff[N-1];
    use_z = m_zf; use_n = m_nf; use_v = m_fv;
`ifdef ALU_ISSUE_FLAG_FWD_EN
    if (cmp_in_ex) begin use_z = live_z; use_n = live_n; use_v = 1'b1; end
`endif
    taken = acc && use_v && (((op == 4'd6) && use_z) || ((op == 4'd7) && use_n));
    if (cmp_in_ex && !fl) begin m_zf = live_z; m_nf = live_n; m_fv = 1'b1; end
    if (acc && op >= 4'd9) m_ill = 1'b1;
    if (fl) begin
      m_ex_valid = 1'b0; m_br = 1'b0;
    end else if (st) begin
      m_br = 1'b0;
    end else begin
      m_br = taken;
      if (acc && op <= 4'd5) begin
        m_a = rs;
        if (op == 4'd4)      m_b = {16'h0, imm};
        else if (op == 4'd5) m_b = {{16{imm[15]}}, imm};
        else                 m_b = rt;
        m_op = (op == 4'd4) ? 2'b00 : (op == 4'd5) ? 2'b01 : op[1:0];
        m_ex_valid = 1'b1;
      end else begin
        m_ex_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd8, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm);
    cyc(1'b0, 1'b1, op, rs, rt, imm, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return $urandom_range(0, 3);
      2:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_rs, r_rt;

    cyc(1'b1, 1'b0, 4'd8, 0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'd8, 0, 0, 0, 1'b0, 1'b0);

    // BLTZ with no valid flags after reset
    issue(4'd7, 0, 0, 0);
    idle();
    check_eq("bltz_after_reset", 32'(br_taken), 32'd0);

    // ADDI sign extension
    issue(4'd5, 32'd5, 0, 16'hFFFF);
    idle();
    check_eq("addi_in1", alu_in1, 32'd5);
    check_eq("addi_in2", alu_in2, 32'hFFFF_FFFF);
    check_eq("addi_op", 32'(alu_op), 32'd1);
    check_eq("addi_valid", 32'(ex_valid), 32'd1);

    // CMP 7,7 then BZ
    issue(4'd3, 32'd7, 32'd7, 0);
    issue(4'd6, 0, 0, 0);
`ifdef ALU_ISSUE_FLAG_FWD_EN
    check_eq("bz_behind_cmp_ready", 32'(in_ready), 32'd1);
`else
    check_eq("bz_behind_cmp_ready", 32'(in_ready), 32'd0);
    issue(4'd6, 0, 0, 0);
    check_eq("bz_retry_ready", 32'(in_ready), 32'd1);
`endif
    idle();
    check_eq("bz_taken", 32'(br_taken), 32'd1);
    idle();

    // ADD held by a three-cycle stall
    issue(4'd1, 32'h11, 32'h22, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'd2, 32'h33, 32'h44, 0, 1'b1, 1'b0);
      check_eq("stall_ready", 32'(in_ready), 32'd0);
      check_eq("stall_in1", alu_in1, 32'h11);
      check_eq("stall_in2", alu_in2, 32'h22);
      check_eq("stall_op", 32'(alu_op), 32'd1);
    end
    issue(4'd2, 32'h33, 32'h44, 0);
    idle();
    check_eq("resume_in1", alu_in1, 32'h33);
    check_eq("resume_op", 32'(alu_op), 32'd2);

    // Flush of a CMP in its EX cycle keeps the older flags (zf=0, nf=1)
    issue(4'd3, 32'd1, 32'd2, 0);
    idle();
    issue(4'd3, 32'd3, 32'd3, 0);
    cyc(1'b0, 1'b1, 4'd6, 0, 0, 0, 1'b0, 1'b1);
    issue(4'd6, 0, 0, 0);
    check_eq("flush_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("flush_state_run", 32'(in_ready), 32'd1);
    issue(4'd7, 0, 0, 0);
    check_eq("flush_bz_not_taken", 32'(br_taken), 32'd0);
    idle();
    check_eq("flush_bltz_taken", 32'(br_taken), 32'd1);

    // Illegal opcode 12 is sticky until reset
    issue(4'd12, 32'h5, 32'h6, 0);
    idle();
    check_eq("illegal_set", 32'(illegal_op), 32'd1);
    check_eq("illegal_bubble", 32'(ex_valid), 32'd0);
    idle();
    idle();
    check_eq("illegal_sticky", 32'(illegal_op), 32'd1);
    cyc(1'b1, 1'b0, 4'd8, 0, 0, 0, 1'b0, 1'b0);
    idle();
    check_eq("illegal_cleared", 32'(illegal_op), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 8) r_op = 4'($urandom_range(0, 8));
      else                          r_op = 4'($urandom_range(9, 15));
      r_rs = rand_val();
      r_rt = ($urandom_range(0, 3) == 0) ? r_rs : rand_val();
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 8), r_op, r_rs, r_rt,
          16'($urandom), 1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 7));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
